br_pre_ctrl_rd_seq: RTL and testbench
=====================================

// Module: br_pre_ctrl_rd_seq
// PURPOSE
//  Read-side sequencer for the bridge pre-control path. Pops one 40-bit control word per
//  packet from the pre-control FIFO, decodes length/tag, then pops ceil(len/8) 64-bit beats
//  from the companion data FIFO. Emits a valid/ready packet stream with sop/eop/byte-enables.
//  Sits in the FIFOs' read-clock domain, downstream of both FIFOs.
// PARAMETERS
//  CTRL_W   40    control word width; [13:0]=byte length, [15:14] rsvd, [39:16]=tag
//  DATA_W   64    data beat width; fixed at 64 in this revision (8 byte lanes)
//  LEN_W    14    length field width
//  MAX_LEN  9600  largest legal packet length in bytes
// PORTS
//  clk         in   1       single clock (FIFO read clock)
//  aclr        in   1       asynchronous, active-high reset
//  ctrl_empty  in   1       control FIFO empty
//  ctrl_q      in   CTRL_W  control FIFO read data, valid the cycle after ctrl_rdreq
//  ctrl_rdreq  out  1       control FIFO pop
//  data_empty  in   1       data FIFO empty
//  data_q      in   DATA_W  data FIFO read data, valid the cycle after data_rdreq
//  data_rdreq  out  1       data FIFO pop
//  out_valid   out  1       stream beat valid
//  out_ready   in   1       stream beat accepted when out_valid & out_ready
//  out_data    out  DATA_W  beat data, byte 0 in [7:0]
//  out_sop     out  1       first beat of packet
//  out_eop     out  1       last beat of packet
//  out_be      out  8       valid byte lanes; 8'hFF except on eop
//  out_tag     out  24      ctrl_q[39:16] of the packet, valid with every beat
//  err_pulse   out  1       one-cycle pulse on illegal length
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, skid buffer empty, in-flight flags clear. aclr mid-packet
//    abandons the packet immediately; the FIFOs are cleared by the same aclr.
//  - FSM: IDLE -> CWAIT -> DATA or DRAIN -> IDLE.
//  - IDLE: ctrl_rdreq = !ctrl_empty; on pop go to CWAIT.
//  - CWAIT: latch ctrl_q; beats = ceil(len/8).
//    - len==0: err_pulse, no data read, go to IDLE.
//    - len>MAX_LEN: err_pulse, go to DRAIN.
//    - Otherwise go to DATA.
//  - DATA: data_rdreq = beats_left!=0 & !data_empty & (occ + inflight - pop) < 2, where
//    occ is the 2-entry skid-buffer occupancy and pop = out_valid & out_ready. One read may be
//    in flight; data_q is written to the skid buffer the cycle after data_rdreq.
//    Each entry carries data, sop (first beat), eop (last beat), be and tag.
//    Leave for IDLE the cycle after the final data_rdreq. The next ctrl pop may overlap with
//    buffered beats of the previous packet.
//  - DRAIN: data_rdreq = beats_left!=0 & !data_empty. Popped beats are discarded and never
//    presented; go to IDLE after the last pop.
//  - Output comes from the skid-buffer head. out_valid = occ!=0. The head holds stable while
//    out_valid & !out_ready.
//  - eop byte enables: rem = len[2:0]; out_be = rem==0 ? 8'hFF : 8'hFF >> (8-rem).
//  - Single-beat packet (len<=8): sop and eop both set on the same beat.
//  - Latency: ctrl_empty falls at cycle 0 with data present -> ctrl_rdreq c0, latch c1,
//    data_rdreq c2, out_valid c4. Sustained 1 beat/clk while out_ready=1 and data_empty=0.
//  - ctrl_rdreq and data_rdreq are never asserted while the matching empty flag is 1.
// CONFIGURATION
//  BR_PRE_CTRL_RD_STATS_EN defined: adds outputs stat_pkts[31:0] (+1 per eop beat accepted),
//    stat_bytes[47:0] (+popcount(out_be) per beat accepted) and stat_errs[15:0] (+1 per
//    err_pulse). All wrap, reset to 0 on aclr.
//  Not defined: the stat_* ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. ctrl len=64, tag=0xABCDEF, 8 beats queued, out_ready=1 -> 8 beats, sop on beat 0,
//     eop on beat 7 with be=FF, tag=ABCDEF on every beat, out_valid first at c4.
//  2. len=13 -> 2 beats, eop be=8'h1F; len=1 -> 1 beat with sop=eop=1, be=8'h01.
//  3. len=0, then len=16 -> err_pulse once, no data_rdreq for the first word, second
//     packet delivered intact.
//  4. len=9601 with 1201 beats, then len=8 -> err_pulse, 1201 beats popped with
//     out_valid=0, then 1 beat out with sop=eop=1.
//  5. Random out_ready (50%) and data_empty gaps across 100 packets -> no beat lost or
//     duplicated, data_rdreq never with data_empty=1, head stable while stalled.
//  6. aclr asserted mid-packet (beat 3 of 8) -> all outputs 0 immediately; next packet after
//     release is correct. With STATS_EN: counters match scoreboard and clear on aclr.

Source files
------------

// File: rtl/br_pre_ctrl_rd_seq_if.sv
// Bundle of the pre-control read sequencer's FIFO-side and stream-side signals.
// master: the sequencer (pops FIFOs, drives the packet stream).
// slave : the environment (FIFOs plus the stream consumer).
`timescale 1ns/1ps
interface br_pre_ctrl_rd_seq_if #(
    parameter int CTRL_W = 40,
    parameter int DATA_W = 64
);
    logic              ctrl_empty;
    logic [CTRL_W-1:0] ctrl_q;
    logic              ctrl_rdreq;
    logic              data_empty;
    logic [DATA_W-1:0] data_q;
    logic              data_rdreq;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic [7:0]        out_be;
    logic [23:0]       out_tag;
    logic              err_pulse;

    modport master (
        input  ctrl_empty, ctrl_q, data_empty, data_q, out_ready,
        output ctrl_rdreq, data_rdreq, out_valid, out_data, out_sop, out_eop,
               out_be, out_tag, err_pulse
    );

    modport slave (
        output ctrl_empty, ctrl_q, data_empty, data_q, out_ready,
        input  ctrl_rdreq, data_rdreq, out_valid, out_data, out_sop, out_eop,
               out_be, out_tag, err_pulse
    );
endinterface

// File: rtl/br_pre_ctrl_rd_seq.sv
// Read-side sequencer for the bridge pre-control path.
// Pops one control word per packet, then ceil(len/8) data beats, and presents them
// as a sop/eop/byte-enable packet stream through a 2-entry skid buffer.
// Illegal lengths pulse err_pulse; over-length packets have their data drained.
// Optional: define BR_PRE_CTRL_RD_STATS_EN to add the stat_pkts/stat_bytes/stat_errs counters.
`timescale 1ns/1ps
module br_pre_ctrl_rd_seq #(
    parameter int CTRL_W  = 40,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 14,
    parameter int MAX_LEN = 9600
) (
    input  logic                 clk,
    input  logic                 aclr,
    br_pre_ctrl_rd_seq_if.master bus
`ifdef BR_PRE_CTRL_RD_STATS_EN
    ,
    output logic [31:0]          stat_pkts,
    output logic [47:0]          stat_bytes,
    output logic [15:0]          stat_errs
`endif
);
    // ceil(len/8) of the largest encodable length (16383) is 2048, which needs LEN_W-2 bits.
    localparam int BEAT_W = LEN_W - 2;

    typedef enum logic [1:0] {IDLE, CWAIT, DATA, DRAIN} state_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [7:0]  be;
        logic [23:0] tag;
    } meta_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        meta_t             meta;
    } entry_t;

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beats_left_reg;
    logic              first_reg;
    logic [2:0]        rem_reg;
    logic [23:0]       tag_reg;
    logic              inflight_reg;
    meta_t             inflight_meta_reg;
    entry_t            skid_reg [2];
    logic              rd_ptr_reg, wr_ptr_reg;
    logic [1:0]        occ_reg;

    logic              ctrl_rdreq_c, data_rdreq_c, err_c;
    logic              out_valid_c, pop, room, last_beat;
    logic [2:0]        occ_after;
    logic [7:0]        be_eop;
    entry_t            head;

    // Control-word decode; only meaningful while the FSM sits in CWAIT.
    logic [LEN_W-1:0]  c_len;
    logic [LEN_W:0]    len_pad;
    logic [BEAT_W-1:0] c_beats;
    logic              len_zero, len_over;
    logic              unused_bits;

    assign c_len       = bus.ctrl_q[LEN_W-1:0];
    assign len_pad     = {1'b0, c_len} + (LEN_W+1)'(7);
    assign c_beats     = len_pad[LEN_W:3];
    assign len_zero    = (c_len == '0);
    assign len_over    = (c_len > LEN_W'(MAX_LEN));
    assign unused_bits = ^{bus.ctrl_q[15:14], len_pad[2:0]};

    assign last_beat   = (beats_left_reg == BEAT_W'(1));
    assign out_valid_c = (occ_reg != 2'd0);
    assign pop         = out_valid_c & bus.out_ready;
    // A new read is allowed only if it still fits once the in-flight beat lands.
    assign occ_after   = {1'b0, occ_reg} + {2'b00, inflight_reg};
    assign room        = occ_after < (3'd2 + {2'b00, pop});

    // Final-beat byte enables: lanes below len%8, or all lanes when len is a multiple of 8.
    for (genvar gi = 0; gi < 8; gi++) begin : g_be
        assign be_eop[gi] = (rem_reg == 3'd0) || (3'(gi) < rem_reg);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (ctrl_rdreq_c) state_next = CWAIT;
            CWAIT: begin
                if (len_zero)      state_next = IDLE;
                else if (len_over) state_next = DRAIN;
                else               state_next = DATA;
            end
            DATA, DRAIN: if (data_rdreq_c && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: FIFO pops and the illegal-length pulse.
    always_comb begin
        ctrl_rdreq_c = 1'b0;
        data_rdreq_c = 1'b0;
        err_c        = 1'b0;
        case (state_reg)
            IDLE:  ctrl_rdreq_c = !bus.ctrl_empty;
            CWAIT: err_c        = len_zero | len_over;
            DATA:  data_rdreq_c = (beats_left_reg != '0) && !bus.data_empty && room;
            DRAIN: data_rdreq_c = (beats_left_reg != '0) && !bus.data_empty;
            default: ;
        endcase
    end

    // Per-packet context: latched in CWAIT, beat count walks down with each data pop.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            beats_left_reg <= '0;
            first_reg      <= 1'b0;
            rem_reg        <= '0;
            tag_reg        <= '0;
        end else if (state_reg == CWAIT) begin
            beats_left_reg <= c_beats;
            first_reg      <= 1'b1;
            rem_reg        <= c_len[2:0];
            tag_reg        <= bus.ctrl_q[CTRL_W-1:16];
        end else if (data_rdreq_c) begin
            beats_left_reg <= beats_left_reg - BEAT_W'(1);
            first_reg      <= 1'b0;
        end
    end

    // In-flight beat tracking. Metadata is captured at pop time so the next packet's
    // control word may be latched before this beat reaches the skid buffer.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            inflight_reg      <= 1'b0;
            inflight_meta_reg <= '0;
        end else begin
            inflight_reg <= data_rdreq_c && (state_reg == DATA);
            if (data_rdreq_c) begin
                inflight_meta_reg <= '{sop: first_reg, eop: last_beat,
                                       be: (last_beat ? be_eop : 8'hFF), tag: tag_reg};
            end
        end
    end

    // 2-entry skid buffer: written from data_q the cycle after the pop, drained by the stream.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < 2; i++) skid_reg[i] <= '0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (inflight_reg) begin
                skid_reg[wr_ptr_reg] <= '{data: bus.data_q, meta: inflight_meta_reg};
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            occ_reg <= occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
        end
    end

    assign head           = skid_reg[rd_ptr_reg];
    assign bus.ctrl_rdreq = ctrl_rdreq_c;
    assign bus.data_rdreq = data_rdreq_c;
    assign bus.err_pulse  = err_c;
    assign bus.out_valid  = out_valid_c;
    // Stream fields are forced to zero whenever nothing is presented.
    assign bus.out_data   = out_valid_c ? head.data     : '0;
    assign bus.out_sop    = out_valid_c & head.meta.sop;
    assign bus.out_eop    = out_valid_c & head.meta.eop;
    assign bus.out_be     = out_valid_c ? head.meta.be  : 8'h00;
    assign bus.out_tag    = out_valid_c ? head.meta.tag : 24'h0;

`ifdef BR_PRE_CTRL_RD_STATS_EN
    // Traffic statistics on accepted beats and error pulses; all counters wrap.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
            stat_errs  <= '0;
        end else begin
            if (pop && head.meta.eop) stat_pkts <= stat_pkts + 32'd1;
            if (pop) stat_bytes <= stat_bytes + 48'($countones(head.meta.be));
            if (err_c) stat_errs <= stat_errs + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_br_pre_ctrl_rd_seq.sv
// Self-checking bench for br_pre_ctrl_rd_seq: FIFO models, scoreboard of expected beats,
// a table of packet vectors plus hand-written latency, drain, random and reset sequences.
`timescale 1ns/1ps
module tb_br_pre_ctrl_rd_seq;
    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [7:0]  be;
        logic [23:0] tag;
    } beat_t;

    typedef struct {
        int          len;
        logic [23:0] tag;
        int          n_data;
        int          n_exp;
        logic [7:0]  last_be;
        int          is_err;
    } vec_t;

    logic clk = 1'b0;
    logic aclr = 1'b1;
    always #5 clk = ~clk;

    br_pre_ctrl_rd_seq_if bus ();
`ifdef BR_PRE_CTRL_RD_STATS_EN
    logic [31:0] stat_pkts;
    logic [47:0] stat_bytes;
    logic [15:0] stat_errs;
`endif

    br_pre_ctrl_rd_seq dut (
        .clk (clk),
        .aclr(aclr),
        .bus (bus)
`ifdef BR_PRE_CTRL_RD_STATS_EN
        ,
        .stat_pkts (stat_pkts),
        .stat_bytes(stat_bytes),
        .stat_errs (stat_errs)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [39:0] ctrl_fifo[$];
    logic [63:0] data_fifo[$];
    beat_t       exp_q[$];
    int ctrl_push_cnt = 0, ctrl_pop_cnt = 0;
    int data_push_cnt = 0, data_pop_cnt = 0;
    logic data_gap = 1'b0;
    logic rdy_rand = 1'b0, rdy_on = 1'b1, gap_en = 1'b0;
    int err_seen = 0, err_exp = 0, acc_cnt = 0;
    longint bytes_m = 0;
    int pkts_m = 0, errs_m = 0;

    assign bus.ctrl_empty = (ctrl_push_cnt == ctrl_pop_cnt);
    assign bus.data_empty = (data_push_cnt == data_pop_cnt) || data_gap;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] be_model(input int len);
        logic [7:0] b;
        int r;
        r = len % 8;
        b = 8'h00;
        if (r == 0) b = 8'hFF;
        else for (int i = 0; i < r; i++) b[i] = 1'b1;
        return b;
    endfunction

    // FIFO models: data appears on q the cycle after the pop; aclr empties both.
    always @(posedge clk or posedge aclr) begin
        if (aclr) begin
            ctrl_fifo.delete();
            data_fifo.delete();
            ctrl_pop_cnt <= ctrl_push_cnt;
            data_pop_cnt <= data_push_cnt;
            bus.ctrl_q   <= '0;
            bus.data_q   <= '0;
        end else begin
            if (bus.ctrl_rdreq) begin
                checks++;
                if (bus.ctrl_empty) begin
                    errors++;
                    $display("FAIL ctrl_rdreq_when_empty: got rdreq=1 expected 0");
                end else begin
                    bus.ctrl_q   <= ctrl_fifo.pop_front();
                    ctrl_pop_cnt <= ctrl_pop_cnt + 1;
                end
            end
            if (bus.data_rdreq) begin
                checks++;
                if (bus.data_empty) begin
                    errors++;
                    $display("FAIL data_rdreq_when_empty: got rdreq=1 expected 0");
                end else begin
                    bus.data_q   <= data_fifo.pop_front();
                    data_pop_cnt <= data_pop_cnt + 1;
                end
            end
        end
    end

    // Stream monitor: drives out_ready/data gaps and pops the scoreboard on accepted beats.
    beat_t prev_beat;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin : mon
        beat_t act, e;
        if (aclr) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.err_pulse) err_seen++;
            act = '{bus.out_data, bus.out_sop, bus.out_eop, bus.out_be, bus.out_tag};
            if (prev_stall) chk("head_stable", 128'({bus.out_valid, act}), 128'({1'b1, prev_beat}));
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_on;
            data_gap      = gap_en && ($urandom_range(0, 3) == 0);
            if (bus.out_valid && bus.out_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h sop=%b eop=%b expected no beat",
                             act.data, act.sop, act.eop);
                end else begin
                    e = exp_q.pop_front();
                    $display("beat data=%h sop=%b eop=%b be=%h tag=%h", act.data, act.sop,
                             act.eop, act.be, act.tag);
                    chk("beat", 128'(act), 128'(e));
                    pkts_m  += int'(e.eop);
                    bytes_m += longint'($countones(e.be));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_beat  = act;
        end
    end

    task automatic send_pkt(input int len, input logic [23:0] tag, input int n_data,
                            input int n_exp, input logic [7:0] last_be, input int is_err);
        logic [63:0] d;
        beat_t b;
        for (int i = 0; i < n_data; i++) begin
            d = {$urandom, $urandom};
            data_fifo.push_back(d);
            data_push_cnt++;
            if (i < n_exp) begin
                b.data = d;
                b.sop  = (i == 0);
                b.eop  = (i == n_exp - 1);
                b.be   = (i == n_exp - 1) ? last_be : 8'hFF;
                b.tag  = tag;
                exp_q.push_back(b);
            end
        end
        ctrl_fifo.push_back({tag, 2'b00, 14'(len)});
        ctrl_push_cnt++;
        if (is_err != 0) begin
            err_exp++;
            errs_m++;
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || ctrl_push_cnt != ctrl_pop_cnt ||
                data_push_cnt != data_pop_cnt) && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (cyc >= 20000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
        end
        chk({name, "_err_count"}, 128'(err_seen), 128'(err_exp));
`ifdef BR_PRE_CTRL_RD_STATS_EN
        chk({name, "_stat_pkts"}, 128'(stat_pkts), 128'(pkts_m));
        chk({name, "_stat_bytes"}, 128'(stat_bytes), 128'(bytes_m));
        chk({name, "_stat_errs"}, 128'(stat_errs), 128'(errs_m));
`endif
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_be, bus.out_tag,
                     bus.out_data, bus.ctrl_rdreq, bus.data_rdreq, bus.err_pulse});
    endfunction

    initial begin : main
        vec_t vt[11];
        int base, cyc, len, nb;
        vt[0]  = '{64,    24'hABCDEF, 8,    8,    8'hFF, 0};
        vt[1]  = '{13,    24'h000013, 2,    2,    8'h1F, 0};
        vt[2]  = '{1,     24'h000001, 1,    1,    8'h01, 0};
        vt[3]  = '{0,     24'h0000A0, 0,    0,    8'h00, 1};
        vt[4]  = '{16,    24'h000016, 2,    2,    8'hFF, 0};
        vt[5]  = '{9601,  24'h009601, 1201, 0,    8'h00, 1};
        vt[6]  = '{8,     24'h000008, 1,    1,    8'hFF, 0};
        vt[7]  = '{7,     24'h000007, 1,    1,    8'h7F, 0};
        vt[8]  = '{9600,  24'h009600, 1200, 1200, 8'hFF, 0};
        vt[9]  = '{9,     24'h000009, 2,    2,    8'h01, 0};
        vt[10] = '{16383, 24'h3FFF00, 2048, 0,    8'h00, 1};

        // Reset state
        @(posedge clk); #1;
        chk("reset_outputs", all_outs(), 128'(0));
        @(posedge clk); #1;
        aclr = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_outputs", all_outs(), 128'(0));

        // Latency: ctrl word and 8 beats appear together in cycle 0
        send_pkt(64, 24'hABCDEF, 8, 8, 8'hFF, 0);
        @(negedge clk); chk("c0_ctrl_rdreq", 128'(bus.ctrl_rdreq), 128'(1));
        @(negedge clk); chk("c1_data_rdreq", 128'(bus.data_rdreq), 128'(0));
                        chk("c1_err_pulse", 128'(bus.err_pulse), 128'(0));
        @(negedge clk); chk("c2_data_rdreq", 128'(bus.data_rdreq), 128'(1));
        @(negedge clk); chk("c3_out_valid", 128'(bus.out_valid), 128'(0));
        @(negedge clk); chk("c4_out_valid", 128'(bus.out_valid), 128'(1));
        wait_idle("latency");

        // Table vectors, one at a time
        for (int i = 0; i < 11; i++) begin
            $display("vector %0d len=%0d tag=%h", i, vt[i].len, vt[i].tag);
            send_pkt(vt[i].len, vt[i].tag, vt[i].n_data, vt[i].n_exp, vt[i].last_be, vt[i].is_err);
            wait_idle("vector");
        end

        // Same table back to back, so packets overlap in the skid buffer
        for (int i = 0; i < 11; i++)
            send_pkt(vt[i].len, vt[i].tag ^ 24'h5A5A5A, vt[i].n_data, vt[i].n_exp,
                     vt[i].last_be, vt[i].is_err);
        wait_idle("burst");

        // Random backpressure and data FIFO gaps
        rdy_rand = 1'b1;
        gap_en   = 1'b1;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 200);
            nb  = (len + 7) / 8;
            send_pkt(len, 24'($urandom), nb, nb, be_model(len), 0);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
        end
        wait_idle("random");
        rdy_rand = 1'b0;
        gap_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a packet (beat 3 of 8 on the output)
        send_pkt(64, 24'h123456, 8, 8, 8'hFF, 0);
        base = acc_cnt;
        cyc  = 0;
        while (acc_cnt < base + 3 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("aclr_reach_beat3", 128'(acc_cnt - base), 128'(3));
        aclr = 1'b1;
        exp_q.delete();
        pkts_m  = 0;
        bytes_m = 0;
        errs_m  = 0;
        #1;
        chk("aclr_outputs_zero", all_outs(), 128'(0));
        @(posedge clk); #1;
        chk("aclr_held_outputs_zero", all_outs(), 128'(0));
`ifdef BR_PRE_CTRL_RD_STATS_EN
        chk("aclr_stats_zero", 128'({stat_pkts, stat_bytes, stat_errs}), 128'(0));
`endif
        aclr = 1'b0;
        @(posedge clk); #1;
        send_pkt(21, 24'h0F0F0F, 3, 3, 8'h1F, 0);
        wait_idle("after_aclr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end
endmodule
